// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with sweep-level debounce and ghosting reject,
// plus an independent debouncer that turns the semitone button into a one-cycle pulse.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SEMI_DEB       = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic       semi_btn,
  output logic [3:0] col_out,
  output logic [7:0] diods,
  output logic       semitone,
  output logic       key_valid,
  output logic [1:0] dbg_state
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int BW = (SEMI_DEB > 1) ? $clog2(SEMI_DEB) : 1;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_t;

  scan_state_t   state, state_nxt;
  logic [SW-1:0] slot;
  logic          slot_end;
  logic          sweep_end;

  logic [3:0]    row_s1, row_s2;
  logic          btn_s1, btn_s2;

  logic [1:0]    key_cnt;
  logic [7:0]    key_code;
  logic [3:0]    hits;
  logic [2:0]    n_hits;
  logic [2:0]    total;
  logic [1:0]    sat_cnt;
  logic [3:0]    first_row;
  logic [7:0]    code_nxt;
  logic [7:0]    cand;

  logic [DW-1:0] stable_cnt;
  logic [7:0]    prev_cand;

  logic          btn_acc;
  logic [BW-1:0] sem_cnt;

  // Two-flop synchronizers; idle levels are rows high and button released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      btn_s1 <= semi_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign slot_end  = (slot == SW'(SCAN_DIV - 1));
  assign sweep_end = slot_end && (state == COL3);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COL0;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_end ? '0 : slot + SW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    col_out   = 4'b1110;
    case (state)
      COL0: begin
        col_out = 4'b1110;
        if (slot_end) state_nxt = COL1;
      end
      COL1: begin
        col_out = 4'b1101;
        if (slot_end) state_nxt = COL2;
      end
      COL2: begin
        col_out = 4'b1011;
        if (slot_end) state_nxt = COL3;
      end
      COL3: begin
        col_out = 4'b0111;
        if (slot_end) state_nxt = COL0;
      end
      default: ;
    endcase
  end

  // Per-slot row evaluation: count pressed keys (saturating at 2) and keep the first one found
  always_comb begin
    hits      = ~row_s2;
    n_hits    = {2'b00, hits[0]} + {2'b00, hits[1]} + {2'b00, hits[2]} + {2'b00, hits[3]};
    total     = {1'b0, key_cnt} + n_hits;
    sat_cnt   = (total >= 3'd2) ? 2'd2 : total[1:0];
    first_row = hits & (~hits + 4'd1);
    code_nxt  = key_code;
    if (key_cnt == 2'd0 && n_hits != 3'd0) code_nxt = {first_row, ~col_out};
    cand      = (sat_cnt == 2'd1) ? code_nxt : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_cnt  <= 2'd0;
      key_code <= 8'h00;
    end else if (sweep_end) begin
      key_cnt  <= 2'd0;
      key_code <= 8'h00;
    end else if (slot_end) begin
      key_cnt  <= sat_cnt;
      key_code <= code_nxt;
    end
  end

  // An empty keypad is a candidate like any other, so release is debounced the same way
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      prev_cand  <= 8'h00;
    end else if (sweep_end) begin
      if (cand == prev_cand) begin
        if (stable_cnt != DW'(DEBOUNCE_SCANS)) stable_cnt <= stable_cnt + DW'(1);
      end else begin
        stable_cnt <= DW'(1);
        prev_cand  <= cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) diods <= 8'h00;
    else if (stable_cnt == DW'(DEBOUNCE_SCANS)) diods <= prev_cand;
  end

  assign key_valid = |diods;

  // Semitone: accept a new level after it has differed from the accepted one for SEMI_DEB cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_acc  <= 1'b0;
      sem_cnt  <= '0;
      semitone <= 1'b0;
    end else begin
      semitone <= 1'b0;
      if (btn_s2 == btn_acc) begin
        sem_cnt <= '0;
      end else if (sem_cnt == BW'(SEMI_DEB - 1)) begin
        btn_acc  <= btn_s2;
        sem_cnt  <= '0;
        semitone <= btn_s2;
      end else begin
        sem_cnt <= sem_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from col_out, and a sweep-level
// reference predicts diods from the set of keys held during each full sweep.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic       semi_btn;
  logic [3:0] col_out;
  logic [7:0] diods;
  logic       semitone;
  logic       key_valid;
  logic [1:0] dbg_state;

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3), .SEMI_DEB(16)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .semi_btn(semi_btn),
    .col_out(col_out), .diods(diods), .semitone(semitone),
    .key_valid(key_valid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven low
  logic [15:0] pressed = 16'h0000;
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sem_hi = 0;
  int sem_cyc = 0;
  always @(negedge clk) if (semitone === 1'b1) begin
    sem_hi  <= sem_hi + 1;
    sem_cyc <= cyc;
  end

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_diods = 8'h00;

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] k;
    k = 16'h0000;
    k[r*4+c] = 1'b1;
    return k;
  endfunction

  // Candidate of a sweep: the single held key's code, or nothing if 0 or 2+ keys are held
  function automatic logic [7:0] cand_of(input logic [15:0] keys);
    logic [3:0] one;
    logic [7:0] code;
    one  = 4'b0001;
    code = 8'h00;
    if ($countones(keys) == 1)
      for (int i = 0; i < 16; i++)
        if (keys[i]) code = {one << (i / 4), one << (i % 4)};
    return code;
  endfunction

  // diods follows a candidate once the last three sweep candidates agree
  task automatic model_push(input logic [7:0] c);
    int n;
    exp_q.push_back(c);
    n = exp_q.size();
    if (n >= 3 && exp_q[n-1] == exp_q[n-2] && exp_q[n-2] == exp_q[n-3]) exp_diods = c;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_diods = 8'h00;
  endtask

  // One full sweep with the given keys held; observes outputs one cycle into the sweep
  task automatic run_sweep(input logic [15:0] keys, output logic [7:0] od, output logic ov,
                           output logic [7:0] ed);
    ed = exp_diods;
    pressed = keys;
    @(posedge clk);
    #1;
    od = diods;
    ov = key_valid;
    repeat (31) @(posedge clk);
    #1;
    model_push(cand_of(keys));
  endtask

  task automatic test_reset;
    logic [7:0] od, ed;
    logic ov;
    #2;
    checks++;
    if (col_out !== 4'b1110 || diods !== 8'h00 || semitone !== 1'b0 || key_valid !== 1'b0)
      $display("FAIL reset_initial: col_out=%b diods=%h semitone=%b key_valid=%b, expected 1110/00/0/0",
               col_out, diods, semitone, key_valid);
    else passes++;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_sweep(key(0, 0), od, ov, ed);
      checks++;
      if (od !== ed || ov !== (|ed))
        $display("FAIL reset_setup sweep %0d: diods=%h valid=%b, expected %h/%b", i, od, ov, ed, |ed);
      else passes++;
    end
    repeat (13) @(posedge clk);
    #1;
    checks++;
    if (diods !== 8'h11) $display("FAIL reset_prekey: diods=%h, expected 11", diods);
    else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (col_out !== 4'b1110 || diods !== 8'h00 || semitone !== 1'b0 || key_valid !== 1'b0)
      $display("FAIL reset_async: col_out=%b diods=%h semitone=%b key_valid=%b, expected 1110/00/0/0",
               col_out, diods, semitone, key_valid);
    else passes++;
    pressed = 16'h0000;
    do_reset();
  endtask

  task automatic test_rotation;
    logic [3:0] pat[4];
    pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    checks++;
    if (col_out !== 4'b1110) $display("FAIL rotation_start: col_out=%b, expected 1110", col_out);
    else passes++;
    for (int k = 1; k <= 4; k++) begin
      repeat (7) @(posedge clk);
      #1;
      checks++;
      if (col_out !== pat[(k-1)%4])
        $display("FAIL rotation_hold %0d: col_out=%b, expected %b", k, col_out, pat[(k-1)%4]);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if (col_out !== pat[k%4])
        $display("FAIL rotation_step %0d: col_out=%b, expected %b", k, col_out, pat[k%4]);
      else passes++;
    end
  endtask

  task automatic test_single_key;
    logic [7:0] od, ed;
    logic ov;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_sweep((i < 4) ? key(1, 2) : 16'h0000, od, ov, ed);
      checks++;
      if (od !== ed || ov !== (|ed))
        $display("FAIL single_key sweep %0d: diods=%h valid=%b, expected %h/%b", i, od, ov, ed, |ed);
      else passes++;
    end
    run_sweep(16'h0000, od, ov, ed);
    checks++;
    if (od !== 8'h00 || ed !== 8'h00)
      $display("FAIL single_key_release: diods=%h, expected 00 (model %h)", od, ed);
    else passes++;
  endtask

  task automatic test_bounce;
    logic [7:0] od, ed;
    logic ov;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      run_sweep((i % 2 == 0) ? key(0, 0) : 16'h0000, od, ov, ed);
      checks++;
      if (od !== ed || ov !== (|ed))
        $display("FAIL bounce sweep %0d: diods=%h valid=%b, expected %h/%b", i, od, ov, ed, |ed);
      else passes++;
    end
  endtask

  task automatic test_ghosting;
    logic [7:0] od, ed;
    logic ov;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_sweep((i < 4) ? key(2, 3) : (key(0, 0) | key(3, 3)), od, ov, ed);
      checks++;
      if (od !== ed || ov !== (|ed))
        $display("FAIL ghosting sweep %0d: diods=%h valid=%b, expected %h/%b", i, od, ov, ed, |ed);
      else passes++;
    end
  endtask

  task automatic test_random_keys;
    logic [7:0] od, ed;
    logic ov;
    logic [15:0] keys;
    int hold, a, b;
    do_reset();
    for (int g = 0; g < 8; g++) begin
      case ($urandom_range(0, 3))
        0: keys = 16'h0000;
        1, 2: keys = key($urandom_range(0, 3), $urandom_range(0, 3));
        default: begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          keys = 16'h0000;
          keys[a] = 1'b1;
          keys[b] = 1'b1;
        end
      endcase
      hold = $urandom_range(1, 4);
      for (int i = 0; i < hold; i++) begin
        run_sweep(keys, od, ov, ed);
        checks++;
        if (od !== ed || ov !== (|ed))
          $display("FAIL random_keys group %0d sweep %0d: diods=%h valid=%b, expected %h/%b",
                   g, i, od, ov, ed, |ed);
        else passes++;
      end
    end
  endtask

  task automatic test_semitone;
    int lens[$];
    int c0, h0, exp_n;
    lens.push_back(30);
    lens.push_back(10);
    for (int i = 0; i < 6; i++)
      lens.push_back($urandom_range(0, 1) ? $urandom_range(1, 12) : $urandom_range(20, 40));
    foreach (lens[i]) begin
      @(posedge clk);
      #1;
      c0 = cyc;
      h0 = sem_hi;
      semi_btn = 1'b1;
      repeat (lens[i]) @(posedge clk);
      #1;
      semi_btn = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      exp_n = (lens[i] >= 16) ? 1 : 0;
      checks++;
      if (sem_hi - h0 !== exp_n)
        $display("FAIL semitone_count len %0d: pulse cycles=%0d, expected %0d", lens[i], sem_hi - h0, exp_n);
      else passes++;
      if (exp_n == 1) begin
        checks++;
        if (sem_cyc - c0 < 17 || sem_cyc - c0 > 19)
          $display("FAIL semitone_delay len %0d: delay=%0d, expected 17..19", lens[i], sem_cyc - c0);
        else passes++;
      end
    end
  endtask

  task automatic test_semi_with_key;
    logic [7:0] od, ed;
    logic ov;
    int c0, h0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          run_sweep(key(2, 1), od, ov, ed);
          checks++;
          if (od !== ed || ov !== (|ed))
            $display("FAIL semi_with_key sweep %0d: diods=%h valid=%b, expected %h/%b", i, od, ov, ed, |ed);
          else passes++;
        end
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        c0 = cyc;
        h0 = sem_hi;
        semi_btn = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        semi_btn = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (sem_hi - h0 !== 1 || sem_cyc - c0 < 17 || sem_cyc - c0 > 19)
          $display("FAIL semi_with_key_pulse: pulse cycles=%0d delay=%0d, expected 1 at 17..19",
                   sem_hi - h0, sem_cyc - c0);
        else passes++;
      end
    join
  endtask

  task automatic test_reset_mid_debounce;
    logic [7:0] od, ed;
    logic ov;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      run_sweep(key(2, 1), od, ov, ed);
      checks++;
      if (od !== ed || ov !== (|ed))
        $display("FAIL mid_debounce_pre sweep %0d: diods=%h valid=%b, expected %h/%b", i, od, ov, ed, |ed);
      else passes++;
    end
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (diods !== 8'h00 || col_out !== 4'b1110)
      $display("FAIL mid_debounce_reset: diods=%h col_out=%b, expected 00/1110", diods, col_out);
    else passes++;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_sweep(key(2, 1), od, ov, ed);
      checks++;
      if (od !== ed || ov !== (|ed))
        $display("FAIL mid_debounce_post sweep %0d: diods=%h valid=%b, expected %h/%b", i, od, ov, ed, |ed);
      else passes++;
    end
    checks++;
    if (ed !== 8'b0100_0010) $display("FAIL mid_debounce_final: model=%h, expected 42", ed);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    semi_btn = 1'b0;
    test_reset();
    test_rotation();
    test_single_key();
    test_bounce();
    test_ghosting();
    test_random_keys();
    test_semitone();
    test_semi_with_key();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
